mf_peak_collector: RTL and testbench

- Sink-side consumer of the matched-filter correlator output stream.
- Accepts one frame of FRAME_LEN signed correlation samples over a valid/ready handshake.
- Tracks the running peak and its sample index, and compares the peak against a threshold captured at frame start.
- Presents one result word per frame to downstream control logic over a second valid/ready handshake.

---
 rtl/mf_peak_collector.sv | 129 ++++++++++++
 tb/tb_mf_peak_collector.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mf_peak_collector.sv
// mf_peak_collector
//   Sink-side consumer of the matched-filter correlator stream. It collects one
//   frame of FRAME_LEN signed samples and tracks the running peak together
//   with the index of its first occurrence. The peak is compared against a
//   threshold captured when the frame opens, and one result word per frame
//   is offered downstream.
//
//   Optional build macro MF_PEAK_ABS_EN: the peak search and the threshold
//   compare work on the magnitude |s_data| (unsigned, DATA_W bits). thresh is
//   then read as unsigned.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   start, thresh         frame open pulse (IDLE only), threshold sampled on it
//   s_valid/s_ready/s_data  sample stream handshake
//   res_valid/res_ready     result handshake
//   res_peak/res_index/res_detect  result word
//   busy, sample_cnt      status: frame in progress, samples accepted so far
module mf_peak_collector #(
    parameter int DATA_W    = 38,
    parameter int FRAME_LEN = 60,
    parameter int IDX_W     = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] thresh,
    input  logic                     s_valid,
    input  logic signed [DATA_W-1:0] s_data,
    output logic                     s_ready,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic signed [DATA_W-1:0] res_peak,
    output logic [IDX_W-1:0]         res_index,
    output logic                     res_detect,
    output logic                     busy,
    output logic [IDX_W-1:0]         sample_cnt
);

    typedef enum logic [1:0] {IDLE, COLLECT, REPORT} state_t;

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);

    state_t                     state;
    state_t                     state_nx;
    logic signed [DATA_W-1:0]   thr_q;
    logic                       first_q;
    logic                       accept;
    logic                       last_accept;
    logic                       take;
    logic [DATA_W-1:0]          key;
    logic [DATA_W-1:0]          peak_nx;

`ifdef MF_PEAK_ABS_EN
    localparam logic [DATA_W-1:0] DATA_ONE = DATA_W'(1);

    // Two's-complement magnitude kept at DATA_W bits unsigned: the most
    // negative input lands exactly on 2^(DATA_W-1) without overflow.
    function automatic logic [DATA_W-1:0] peak_key(input logic signed [DATA_W-1:0] d);
        return d[DATA_W-1] ? ((~d) + DATA_ONE) : d;
    endfunction

    function automatic logic peak_gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return a > b;
    endfunction
`else
    function automatic logic [DATA_W-1:0] peak_key(input logic signed [DATA_W-1:0] d);
        return d;
    endfunction

    function automatic logic peak_gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return $signed(a) > $signed(b);
    endfunction
`endif

    assign s_ready     = (state == COLLECT);
    assign res_valid   = (state == REPORT);
    assign busy        = (state != IDLE);
    assign accept      = s_valid && s_ready;
    assign last_accept = accept && (sample_cnt == LAST_IDX);
    assign key         = peak_key(s_data);
    // Strict compare keeps the earliest index on ties.
    assign take        = accept && (first_q || peak_gt(key, res_peak));
    assign peak_nx     = take ? key : res_peak;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start)       state_nx = COLLECT;
            COLLECT: if (last_accept) state_nx = REPORT;
            REPORT:  if (res_ready)   state_nx = IDLE;
            default:                  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sample_cnt <= '0;
            first_q    <= 1'b0;
            thr_q      <= '0;
            res_peak   <= '0;
            res_index  <= '0;
            res_detect <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                thr_q      <= thresh;
                sample_cnt <= '0;
                first_q    <= 1'b1;
            end
            if (accept) begin
                first_q <= 1'b0;
                if (take) begin
                    res_peak  <= key;
                    res_index <= sample_cnt;
                end
                if (!last_accept)
                    sample_cnt <= sample_cnt + IDX_ONE;
            end
            // Detect uses the peak including the final sample, so it is
            // valid on the first REPORT cycle.
            if (last_accept)
                res_detect <= peak_gt(peak_nx, thr_q);
        end
    end

endmodule

// File: tb/tb_mf_peak_collector.sv
// Testbench for mf_peak_collector: randomized and directed frames, expected
// results from a reference model pushed into a queue, monitor compares.
module tb_mf_peak_collector;

    localparam int DW = 38;
    localparam int FL = 60;
    localparam int IW = 6;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic signed [DW-1:0] thresh = '0;
    logic                 s_valid = 1'b0;
    logic signed [DW-1:0] s_data = '0;
    logic                 s_ready;
    logic                 res_valid;
    logic                 res_ready = 1'b0;
    logic signed [DW-1:0] res_peak;
    logic [IW-1:0]        res_index;
    logic                 res_detect;
    logic                 busy;
    logic [IW-1:0]        sample_cnt;

    mf_peak_collector #(.DATA_W(DW), .FRAME_LEN(FL), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .start(start), .thresh(thresh),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_peak(res_peak), .res_index(res_index), .res_detect(res_detect),
        .busy(busy), .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] peak;
        logic [IW-1:0] idx;
        logic          det;
    } exp_t;

    exp_t                 exp_q[$];
    logic signed [DW-1:0] frame [FL];
    int                   n_pass = 0;
    int                   n_total = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    endfunction

    // Reference: find the maximum key over the frame, then the first index
    // holding it; detect is max key > threshold in the same number domain.
    function automatic exp_t model(input logic signed [DW-1:0] t);
        exp_t   e;
        longint keys [FL];
        longint best;
        longint th;
        int     bi;
        for (int i = 0; i < FL; i++) begin
`ifdef MF_PEAK_ABS_EN
            keys[i] = (frame[i] < 0) ? -longint'(frame[i]) : longint'(frame[i]);
`else
            keys[i] = longint'(frame[i]);
`endif
        end
`ifdef MF_PEAK_ABS_EN
        th = longint'($unsigned(t));
`else
        th = longint'(t);
`endif
        best = keys[0];
        for (int i = 1; i < FL; i++) if (keys[i] > best) best = keys[i];
        bi = FL;
        for (int i = FL - 1; i >= 0; i--) if (keys[i] == best) bi = i;
        e.peak = best[DW-1:0];
        e.idx  = IW'(bi);
        e.det  = best > th;
        return e;
    endfunction

    function automatic logic signed [DW-1:0] rnd_data();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return DW'(r);
    endfunction

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t cur;
        int   acc_cnt;
        bit   prev_valid, want_valid, want_idle;
        acc_cnt = 0; prev_valid = 0; want_valid = 0; want_idle = 0;
        cur.peak = '0; cur.idx = '0; cur.det = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                acc_cnt = 0; prev_valid = 0; want_valid = 0; want_idle = 0;
            end else begin
                if (want_valid) begin
                    check("latency_res_valid", res_valid, 1);
                    want_valid = 0;
                end
                if (want_idle) begin
                    check("idle_after_handshake", busy, 0);
                    want_idle = 0;
                end
                if (!busy && s_valid) check("idle_s_ready", s_ready, 0);
                if (s_ready) check("sample_cnt", sample_cnt, acc_cnt);
                if (res_valid) begin
                    if (!prev_valid) begin
                        check("accept_count", acc_cnt, FL);
                        acc_cnt = 0;
                        if (exp_q.size() == 0) check("unexpected_result", 1, 0);
                        else cur = exp_q.pop_front();
                    end
                    check("res_peak", $unsigned(res_peak), cur.peak);
                    check("res_index", res_index, cur.idx);
                    check("res_detect", res_detect, cur.det);
                    check("report_s_ready", s_ready, 0);
                    if (res_ready) want_idle = 1;
                end
                if (s_valid && s_ready) begin
                    acc_cnt++;
                    if (acc_cnt == FL) want_valid = 1;
                end
                prev_valid = res_valid;
            end
        end
    end

    // ---------------- driver ----------------
    // vmode: 0 = continuous, 1 = every other cycle, 2 = random gaps
    task automatic run_frame(input logic signed [DW-1:0] t, input int vmode,
                             input bit stall, input bit poke);
        int i, cyc;
        bit acc, tog;
        exp_q.push_back(model(t));
        start = 1'b1; thresh = t;
        @(posedge clk); #1;
        start = 1'b0; thresh = rnd_data();
        i = 0; cyc = 0; tog = 1'b1;
        while (i < FL && cyc < 1000) begin
            case (vmode)
                0: s_valid = 1'b1;
                1: begin s_valid = tog; tog = ~tog; end
                default: s_valid = ($urandom_range(0, 3) != 0);
            endcase
            s_data = s_valid ? frame[i] : rnd_data();
            start  = poke && (cyc == 15);
            @(negedge clk);
            acc = s_valid && s_ready;
            @(posedge clk); #1;
            if (acc) i++;
            cyc++;
        end
        if (i < FL) check("collect_timeout", i, FL);
        start = 1'b0; s_valid = $urandom_range(0, 1); s_data = rnd_data();
        res_ready = !stall;
        check("report_entered", res_valid, 1);
        if (stall) begin
            for (int k = 0; k < 5; k++) begin
                start = poke && (k == 2);
                @(posedge clk); #1;
            end
            start = 1'b0;
            res_ready = 1'b1;
        end
        @(posedge clk); #1;
        res_ready = 1'b0;
        cyc = 0;
        while (busy && cyc < 10) begin @(posedge clk); #1; cyc++; end
        check("return_idle", busy, 0);
        // Valid data offered in IDLE must be ignored.
        s_valid = 1'b1; s_data = rnd_data();
        repeat (2) begin @(posedge clk); #1; end
        s_valid = 1'b0;
    endtask

    task automatic reset_mid_frame();
        int n, cyc;
        bit acc;
        start = 1'b1; thresh = rnd_data();
        @(posedge clk); #1;
        start = 1'b0;
        n = 0; cyc = 0;
        while (n < 10 && cyc < 100) begin
            s_valid = 1'b1; s_data = rnd_data();
            @(negedge clk);
            acc = s_valid && s_ready;
            @(posedge clk); #1;
            if (acc) n++;
            cyc++;
        end
        s_valid = 1'b0;
        check("pre_reset_cnt", sample_cnt, 10);
        rst = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_sample_cnt", sample_cnt, 0);
        check("rst_res_valid", res_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("post_reset_idle", busy, 0);
    endtask

    initial begin : driver
        logic signed [DW-1:0] most_neg;
        most_neg = '0;
        most_neg[DW-1] = 1'b1;

        #2;
        check("reset_res_peak", $unsigned(res_peak), 0);
        check("reset_res_index", res_index, 0);
        check("reset_res_detect", res_detect, 0);
        check("reset_sample_cnt", sample_cnt, 0);
        check("reset_busy", busy, 0);
        check("reset_s_ready", s_ready, 0);
        check("reset_res_valid", res_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        reset_mid_frame();

        for (int i = 0; i < FL; i++) frame[i] = DW'(i);
        run_frame(DW'(100), 0, 1'b0, 1'b0);

        for (int i = 0; i < FL; i++) frame[i] = -DW'(500);
        frame[7] = -DW'(3); frame[31] = -DW'(3);
        run_frame(-DW'(10), 0, 1'b0, 1'b0);

        for (int i = 0; i < FL; i++) frame[i] = rnd_data();
        run_frame(rnd_data(), 1, 1'b1, 1'b1);

        for (int i = 0; i < FL; i++) frame[i] = '0;
        frame[0] = DW'(40); frame[1] = -DW'(90); frame[2] = DW'(90); frame[3] = DW'(12);
        run_frame(DW'(89), 0, 1'b0, 1'b0);

        for (int i = 0; i < FL; i++) frame[i] = -DW'(7);
        frame[45] = most_neg;
        run_frame(most_neg, 2, 1'b0, 1'b0);

        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < FL; i++)
                frame[i] = (f % 2 == 0) ? rnd_data() : DW'($signed($urandom_range(0, 8)) - 4);
            run_frame((f % 2 == 0) ? rnd_data() : DW'($signed($urandom_range(0, 8)) - 4),
                      $urandom_range(0, 2), $urandom_range(0, 1), $urandom_range(0, 1));
        end

        repeat (3) begin @(posedge clk); #1; end
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
